// File: rtl/aes_text_out_unloader_if.sv
// Output beat stream of the AES text_out unloader: valid/ready handshake with
// the beat payload and an end-of-block marker.
interface aes_text_out_unloader_if #(
    parameter int OUT_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/aes_text_out_unloader.sv
// Captures the 128-bit AES ciphertext on done and streams it out MSW-first as
// OUT_W-bit beats, with a one-deep pending slot and a sticky overrun flag.
//
// state | meaning
// IDLE  | nothing to send, out_valid low, out_data forced to zero
// SEND  | shadow is being streamed, cnt selects the current beat
module aes_text_out_unloader #(
    parameter int DATA_W = 128,
    parameter int OUT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done,
    input  logic [DATA_W-1:0]      text_out,
    aes_text_out_unloader_if.master out_if,
    output logic                   busy,
    output logic                   overrun
);
    localparam int BEATS = DATA_W / OUT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   shadow, shadow_n;
    logic                pend_valid, pend_valid_n;
    logic [DATA_W-1:0]   pend_data, pend_data_n;
    logic                overrun_q, overrun_n;
    logic [DATA_W-1:0]   shifted;
    logic                hs;
    logic                block_end;

    assign shifted   = shadow << (OUT_W * cnt);
    assign hs        = (state == SEND) && out_if.out_ready;
    assign block_end = hs && (cnt == LAST_BEAT);

    assign out_if.out_valid = (state == SEND);
    assign out_if.out_data  = (state == SEND) ? shifted[DATA_W-1 -: OUT_W] : '0;
    assign out_if.out_last  = (state == SEND) && (cnt == LAST_BEAT);
    assign busy             = (state == SEND) || pend_valid;
    assign overrun          = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shadow     <= shadow_n;
            pend_valid <= pend_valid_n;
            pend_data  <= pend_data_n;
            overrun_q  <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shadow_n     = shadow;
        pend_valid_n = pend_valid;
        pend_data_n  = pend_data;
        overrun_n    = overrun_q;

        unique case (state)
            IDLE: begin
                if (done) begin
                    shadow_n = text_out;
                    cnt_n    = '0;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (block_end) begin
                    cnt_n = '0;
                    // Pending block takes priority; a coincident done refills the slot.
                    if (pend_valid) begin
                        shadow_n = pend_data;
                        if (done) begin
                            pend_data_n = text_out;
                        end else begin
                            pend_valid_n = 1'b0;
                        end
                    end else if (done) begin
                        shadow_n = text_out;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (hs) begin
                        cnt_n = cnt + 1'b1;
                    end
                    if (done) begin
                        if (!pend_valid) begin
                            pend_data_n  = text_out;
                            pend_valid_n = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
